// File: rtl/scene_engine.sv
// scene_engine: position/velocity state for N_OBJ square sprites, advanced once
// per frame by one shared, time-multiplexed physics datapath, plus a two-stage
// pixel compositor with collision shading.
module scene_engine #(
  parameter int                    N_OBJ     = 8,
  parameter int                    SIZE      = 50,
  parameter int                    X_DISPLAY = 640,
  parameter int                    Y_DISPLAY = 480,
  parameter logic [N_OBJ*10-1:0]   X_INIT    = '0,
  parameter logic [N_OBJ*10-1:0]   Y_INIT    = '0,
  parameter logic [N_OBJ*4-1:0]    VX_INIT   = '0,
  parameter logic [N_OBJ*4-1:0]    VY_INIT   = '0,
  parameter logic [N_OBJ*2-1:0]    MODE      = '0,
  parameter logic [N_OBJ*12-1:0]   COLORS    = {N_OBJ{12'hfff}}
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pause,
  input  logic        frame_tick,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic [11:0] out,
  output logic [3:0]  collision_num,
  output logic        busy,
  output logic [7:0]  frame_count
);

  localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBJ - 1);
  localparam logic signed [11:0] XD   = 12'(X_DISPLAY);
  localparam logic signed [11:0] YD   = 12'(Y_DISPLAY);
  localparam logic signed [11:0] XMAX = 12'(X_DISPLAY - SIZE);
  localparam logic signed [11:0] YMAX = 12'(Y_DISPLAY - SIZE);
  localparam logic [10:0]        SIZE11 = 11'(SIZE);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_COMMIT} state_e;
  typedef enum logic [1:0] {M_WRAP, M_BOUNCE, M_FULL_RESET, M_STATIC} mode_e;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             busy_q;
  logic [7:0]       frame_count_q;

  logic [9:0]       pos_x_q [N_OBJ];
  logic [9:0]       pos_y_q [N_OBJ];
  logic [3:0]       vel_x_q [N_OBJ];
  logic [3:0]       vel_y_q [N_OBJ];
  logic [9:0]       dx_q    [N_OBJ];
  logic [9:0]       dy_q    [N_OBJ];

  // Physics datapath result for the object selected by idx_q.
  logic [9:0]        new_x_d, new_y_d;
  logic [3:0]        new_vx_d, new_vy_d;
  logic signed [11:0] nx, ny;
  mode_e             mode;

  // Shared physics step: next position/velocity of object idx_q.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // one unassigned and no latch is inferred.
    mode     = mode_e'(MODE[2*idx_q +: 2]);
    nx       = $signed({2'b00, pos_x_q[idx_q]}) + $signed({{8{vel_x_q[idx_q][3]}}, vel_x_q[idx_q]});
    ny       = $signed({2'b00, pos_y_q[idx_q]}) + $signed({{8{vel_y_q[idx_q][3]}}, vel_y_q[idx_q]});
    new_x_d  = pos_x_q[idx_q];
    new_y_d  = pos_y_q[idx_q];
    new_vx_d = vel_x_q[idx_q];
    new_vy_d = vel_y_q[idx_q];
    case (mode)
      M_WRAP: begin
        if (nx < 12'sd0)     new_x_d = 10'(nx + XD);
        else if (nx >= XD)   new_x_d = 10'(nx - XD);
        else                 new_x_d = nx[9:0];
        if (ny < 12'sd0)     new_y_d = 10'(ny + YD);
        else if (ny >= YD)   new_y_d = 10'(ny - YD);
        else                 new_y_d = ny[9:0];
      end
      M_BOUNCE: begin
        if (nx < 12'sd0) begin
          new_x_d  = '0;
          new_vx_d = -vel_x_q[idx_q];
        end else if (nx > XMAX) begin
          new_x_d  = XMAX[9:0];
          new_vx_d = -vel_x_q[idx_q];
        end else begin
          new_x_d  = nx[9:0];
        end
        if (ny < 12'sd0) begin
          new_y_d  = '0;
          new_vy_d = -vel_y_q[idx_q];
        end else if (ny > YMAX) begin
          new_y_d  = YMAX[9:0];
          new_vy_d = -vel_y_q[idx_q];
        end else begin
          new_y_d  = ny[9:0];
        end
      end
      M_FULL_RESET: begin
        if (nx < 12'sd0 || nx >= XD || ny < 12'sd0 || ny >= YD) begin
          new_x_d  = X_INIT[10*idx_q +: 10];
          new_y_d  = Y_INIT[10*idx_q +: 10];
          new_vx_d = VX_INIT[4*idx_q +: 4];
          new_vy_d = VY_INIT[4*idx_q +: 4];
        end else begin
          new_x_d  = nx[9:0];
          new_y_d  = ny[9:0];
        end
      end
      default: ; // static object keeps its state
    endcase
  end

  // Sweep FSM: one object per cycle, then publish all positions at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the object state arrays are small register banks whose reset
      // value is the scene's starting layout, so they are reset like any flop.
      for (int i = 0; i < N_OBJ; i++) begin
        pos_x_q[i] <= X_INIT[10*i +: 10];
        pos_y_q[i] <= Y_INIT[10*i +: 10];
        vel_x_q[i] <= VX_INIT[4*i +: 4];
        vel_y_q[i] <= VY_INIT[4*i +: 4];
        dx_q[i]    <= X_INIT[10*i +: 10];
        dy_q[i]    <= Y_INIT[10*i +: 10];
      end
      state_q       <= S_IDLE;
      idx_q         <= '0;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here sees
      // the pre-edge values of the others regardless of statement order.
      case (state_q)
        S_IDLE: begin
          if (frame_tick && !pause) begin
            state_q <= S_SWEEP;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_SWEEP: begin
          pos_x_q[idx_q] <= new_x_d;
          pos_y_q[idx_q] <= new_y_d;
          vel_x_q[idx_q] <= new_vx_d;
          vel_y_q[idx_q] <= new_vy_d;
          if (idx_q == LAST_IDX) state_q <= S_COMMIT;
          else                   idx_q   <= idx_q + 1'b1;
        end
        S_COMMIT: begin
          for (int i = 0; i < N_OBJ; i++) begin
            dx_q[i] <= pos_x_q[i];
            dy_q[i] <= pos_y_q[i];
          end
          frame_count_q <= frame_count_q + 8'd1;
          busy_q        <= 1'b0;
          idx_q         <= '0;
          state_q       <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Pixel stage 1: which sprites cover (x, y), using display copies only.
  logic [N_OBJ-1:0] hit_d, hit_q;

  always_comb begin
    hit_d = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      hit_d[i] = ({1'b0, x} >= {1'b0, dx_q[i]}) && ({1'b0, x} < ({1'b0, dx_q[i]} + SIZE11)) &&
                 ({1'b0, y} >= {1'b0, dy_q[i]}) && ({1'b0, y} < ({1'b0, dy_q[i]} + SIZE11));
    end
  end

  // Register the hit vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hit_q <= '0;
    else       hit_q <= hit_d;
  end

  // Pixel stage 2: count hits, pick priority colour, apply collision palette.
  logic [4:0]  hit_cnt;
  logic [11:0] prio_color;
  logic [11:0] out_d;
  logic [3:0]  coll_d;

  always_comb begin
    hit_cnt    = '0;
    prio_color = 12'h000;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      hit_cnt = hit_cnt + 5'(hit_q[i]);
      if (hit_q[i]) prio_color = COLORS[12*i +: 12];
    end
    case (hit_cnt)
      5'd0:    out_d = 12'h000;
      5'd1:    out_d = prio_color;
      5'd2:    out_d = 12'h999;
      5'd3:    out_d = 12'h777;
      5'd4:    out_d = 12'h555;
      5'd5:    out_d = 12'h333;
      default: out_d = 12'h111;
    endcase
    coll_d = (hit_cnt > 5'd15) ? 4'd15 : hit_cnt[3:0];
  end

  // Register the composited pixel.
  logic [11:0] out_q;
  logic [3:0]  coll_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= 12'h000;
      coll_q <= 4'd0;
    end else begin
      out_q  <= out_d;
      coll_q <= coll_d;
    end
  end

  assign out           = out_q;
  assign collision_num = coll_q;
  assign busy          = busy_q;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_scene_engine.sv
// Directed bench for scene_engine: seven objects covering wrap, bounce,
// full-reset and static modes, plus an overlapping static cluster.
module tb_scene_engine;

  localparam int N = 7;

  // Object layout, index 0 in the low bits.
  //   0 WRAP       (638,300) v=(+3, 0)  f00
  //   1 BOUNCE     (588,400) v=(+5, 0)  0f0
  //   2 FULL_RESET (635, 10) v=(+3,+2)  00f
  //   3 STATIC     ( 10, 10) v=(+5,-3)  ff0
  //   4 STATIC     (100,100)            0ff
  //   5 STATIC     (110,110)            f0f
  //   6 STATIC     ( 90, 90)            123
  localparam logic [N*10-1:0] XI = {10'd90, 10'd110, 10'd100, 10'd10, 10'd635, 10'd588, 10'd638};
  localparam logic [N*10-1:0] YI = {10'd90, 10'd110, 10'd100, 10'd10, 10'd10, 10'd400, 10'd300};
  localparam logic [N*4-1:0]  VXI = {4'd0, 4'd0, 4'd0, 4'd5, 4'd3, 4'd5, 4'd3};
  localparam logic [N*4-1:0]  VYI = {4'd0, 4'd0, 4'd0, 4'hd, 4'd2, 4'd0, 4'd0};
  localparam logic [N*2-1:0]  MD  = {2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
  localparam logic [N*12-1:0] CL  = {12'h123, 12'hf0f, 12'h0ff, 12'hff0, 12'h00f, 12'h0f0, 12'hf00};

  logic        clk = 1'b0;
  logic        reset;
  logic        pause;
  logic        frame_tick;
  logic [9:0]  x, y;
  logic [11:0] out;
  logic [3:0]  collision_num;
  logic        busy;
  logic [7:0]  frame_count;

  int total = 0;
  int bad   = 0;
  int bcnt;
  logic [11:0] mid_out;

  scene_engine #(
    .N_OBJ(N), .SIZE(50), .X_DISPLAY(640), .Y_DISPLAY(480),
    .X_INIT(XI), .Y_INIT(YI), .VX_INIT(VXI), .VY_INIT(VYI),
    .MODE(MD), .COLORS(CL)
  ) dut (
    .clk(clk), .reset(reset), .pause(pause), .frame_tick(frame_tick),
    .x(x), .y(y), .out(out), .collision_num(collision_num),
    .busy(busy), .frame_count(frame_count)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Drive a pixel, let it through both pipeline stages, check colour and count.
  task automatic probe(input string tag, input int px, input int py,
                       input logic [11:0] eo, input logic [3:0] ec);
    @(negedge clk);
    x = 10'(px);
    y = 10'(py);
    repeat (3) @(negedge clk);
    check({tag, "_out"}, 16'(out), 16'(eo));
    check({tag, "_num"}, 16'(collision_num), 16'(ec));
  endtask

  // One tick, then watch a fixed 30-cycle window counting busy cycles.
  // Optionally re-tick mid-sweep or raise pause mid-sweep; out sampled at cycle 4.
  task automatic run_frame(input bit retick, input bit pause_mid,
                           output int busy_cycles, output logic [11:0] out_mid);
    busy_cycles = 0;
    out_mid     = 12'h000;
    @(negedge clk);
    frame_tick = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      frame_tick = retick && (i == 1);
      if (pause_mid && i == 0) pause = 1'b1;
      if (busy) busy_cycles++;
      if (i == 4) out_mid = out;
    end
    pause = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pause = 1'b0; frame_tick = 1'b0; x = '0; y = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_fc",   16'(frame_count), 16'd0);
    check("rst_out",  16'(out), 16'h000);
    check("rst_num",  16'(collision_num), 16'd0);
    reset = 1'b0;

    // Initial layout visible straight out of reset.
    probe("init_obj3",  15,  15, 12'hff0, 4'd1);
    probe("init_obj0", 638, 300, 12'hf00, 4'd1);
    probe("init_left0", 637, 300, 12'h000, 4'd0);

    // Collision shading.
    probe("coll3",  120, 120, 12'h777, 4'd3);
    probe("coll2",  105, 105, 12'h999, 4'd2);
    probe("single6", 95,  95, 12'h123, 4'd1);
    probe("bg",     300, 200, 12'h000, 4'd0);

    // Paused tick: no sweep.
    @(negedge clk);
    pause = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    pause = 1'b0;
    check("pause_busy", 16'(bcnt), 16'd0);
    check("pause_fc",   16'(frame_count), 16'd0);

    // Frame 1, with a no-tearing check on obj0's old position mid-sweep.
    @(negedge clk);
    x = 10'd638; y = 10'd300;
    repeat (3) @(negedge clk);
    run_frame(1'b0, 1'b0, bcnt, mid_out);
    check("f1_busy_len", 16'(bcnt), 16'(N + 1));
    check("f1_no_tear",  16'(mid_out), 16'hf00);
    check("f1_fc",       16'(frame_count), 16'd1);
    probe("f1_wrap_in",     1, 300, 12'hf00, 4'd1);
    probe("f1_wrap_edge",   0, 300, 12'h000, 4'd0);
    probe("f1_bounce_in", 590, 400, 12'h0f0, 4'd1);
    probe("f1_bounce_edge", 589, 400, 12'h000, 4'd0);
    probe("f1_fr_in",     638,  12, 12'h00f, 4'd1);
    probe("f1_fr_edgey",  638,  11, 12'h000, 4'd0);
    probe("f1_static_in",  10,  10, 12'hff0, 4'd1);
    probe("f1_static_edge", 9,  10, 12'h000, 4'd0);

    // Frame 2, with a second tick mid-sweep that must be ignored.
    run_frame(1'b1, 1'b0, bcnt, mid_out);
    check("f2_busy_len", 16'(bcnt), 16'(N + 1));
    check("f2_fc",       16'(frame_count), 16'd2);
    probe("f2_wrap_in",     4, 300, 12'hf00, 4'd1);
    probe("f2_wrap_edge",   3, 300, 12'h000, 4'd0);
    probe("f2_bounce_in", 585, 400, 12'h0f0, 4'd1);
    probe("f2_bounce_edge", 584, 400, 12'h000, 4'd0);
    probe("f2_fr_reload", 635,  10, 12'h00f, 4'd1);
    probe("f2_fr_edge",   634,  10, 12'h000, 4'd0);

    // Reset while the sweep is at idx=1.
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    check("mid_busy_before", 16'(busy), 16'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 16'(busy), 16'd0);
    check("mid_rst_fc",   16'(frame_count), 16'd0);
    check("mid_rst_out",  16'(out), 16'h000);
    @(negedge clk);
    reset = 1'b0;
    probe("mid_rst_obj0",  638, 300, 12'hf00, 4'd1);
    probe("mid_rst_obj1",  588, 400, 12'h0f0, 4'd1);
    probe("mid_rst_obj1e", 587, 400, 12'h000, 4'd0);
    probe("mid_rst_obj2",  635,  10, 12'h00f, 4'd1);

    // Pause raised during a sweep does not cut it short.
    run_frame(1'b0, 1'b1, bcnt, mid_out);
    check("pmid_busy_len", 16'(bcnt), 16'(N + 1));
    check("pmid_fc",       16'(frame_count), 16'd1);

    // Frame counter wrap 255 -> 0.
    for (int f = 0; f < 254; f++) begin
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      repeat (N + 3) @(negedge clk);
    end
    check("fc_255", 16'(frame_count), 16'd255);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (N + 3) @(negedge clk);
    check("fc_wrap", 16'(frame_count), 16'd0);
    check("fc_idle", 16'(busy), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
